// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry layout for the instruction fetch queue.
package fetch_pkg;

    localparam int unsigned WORD_BYTES   = 4;
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    localparam logic [FETCH_ADDR_W-1:0] DEFAULT_RESET_PC = '0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched instructions; flush empties it in one edge.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Credit-throttled instruction prefetcher in front of a synchronous block ROM,
// presenting fetched words in program order with their byte PCs.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned USED_W = CNT_W + 1;

    // Same layout as fetch_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(WORD_BYTES - 1);
    endfunction

    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [CNT_W-1:0]  count;
    logic              push;
    logic              pop;
    entry_t            push_data;
    entry_t            head;

    // Issue only when every outstanding response is guaranteed a free slot.
    assign mem_en   = rsta_n && !redirect
                      && ((USED_W'(count) + USED_W'(inflight)) < USED_W'(DEPTH));
    assign mem_addr = pc >> 2;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            pc          <= word_align(RESET_PC);
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= word_align(redirect_pc);
            inflight <= 1'b0;
        end else begin
            inflight <= mem_en;
            if (mem_en) begin
                pc          <= pc + ADDR_W'(WORD_BYTES);
                inflight_pc <= pc;
            end
        end
    end

    // A redirect kills the response arriving on the same edge.
    assign push      = inflight && !redirect;
    assign pop       = instr_valid && instr_ready && !redirect;
    assign push_data = '{pc: inflight_pc, instr: mem_rdata};

    fetch_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clka),
        .rst_n     (rsta_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? head.instr : '0;
    assign instr_pc    = instr_valid ? head.pc    : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: queue-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        int          cyc;
    } log_t;

    logic        clka;
    logic        rsta_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    logic        redirect8;
    logic [7:0]  redirect_pc8;
    logic        mem_en8;
    logic [7:0]  mem_addr8;
    logic [31:0] mem_rdata8;
    logic        instr_valid8;
    logic        instr_ready8;
    logic [31:0] instr8;
    logic [7:0]  instr_pc8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [31:0] m_q[$];
    int          m_inf;
    logic [31:0] m_inf_pc;
    logic [31:0] m_pc;

    log_t dlog[$];
    log_t log8[$];

    instr_fetch_queue #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clka(clka), .rsta_n(rsta_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
    );

    instr_fetch_queue #(
        .ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(8'hF8)
    ) dut8 (
        .clka(clka), .rsta_n(rsta_n), .redirect(redirect8), .redirect_pc(redirect_pc8),
        .mem_en(mem_en8), .mem_addr(mem_addr8), .mem_rdata(mem_rdata8),
        .instr_valid(instr_valid8), .instr_ready(instr_ready8), .instr(instr8), .instr_pc(instr_pc8)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    function automatic logic [31:0] rom_word(input logic [31:0] w);
        return w + 32'h100;
    endfunction

    // Synchronous block ROM: data valid the cycle after the enable edge.
    always @(posedge clka) begin
        if (mem_en)  mem_rdata  <= rom_word(mem_addr);
        if (mem_en8) mem_rdata8 <= rom_word(32'(mem_addr8));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_entry(input string name, input bit present, input log_t e,
                             input logic [31:0] epc, input logic [31:0] eins);
        checks++;
        if (!present) begin
            errors++;
            $display("FAIL %s: entry missing, required pc=%h instr=%h", name, epc, eins);
        end else if (e.pc !== epc || e.ins !== eins) begin
            errors++;
            $display("FAIL %s: got pc=%h instr=%h required pc=%h instr=%h",
                     name, e.pc, e.ins, epc, eins);
        end
    endtask

    // Compare DUT outputs with the model at the falling edge and log consumed words.
    task automatic cmp();
        logic        e_en;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        @(negedge clka);
        if (!rsta_n) begin
            chk("rst_mem_en", 32'(mem_en), 32'h0);
            chk("rst_valid", 32'(instr_valid), 32'h0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", instr_pc, 32'h0);
        end else begin
            e_en    = !redirect && ((m_q.size() + m_inf) < DEPTH);
            e_valid = (m_q.size() != 0);
            e_pc    = e_valid ? m_q[0] : 32'h0;
            e_ins   = e_valid ? rom_word(m_q[0] >> 2) : 32'h0;
            chk("mem_en", 32'(mem_en), 32'(e_en));
            chk("mem_addr", mem_addr, m_pc >> 2);
            chk("instr_valid", 32'(instr_valid), 32'(e_valid));
            chk("instr", instr, e_ins);
            chk("instr_pc", instr_pc, e_pc);
            if (instr_valid && instr_ready) dlog.push_back('{instr_pc, instr, cyc});
            if (instr_valid8 && log8.size() < 4) log8.push_back('{32'(instr_pc8), instr8, cyc});
        end
    endtask

    // Advance the model across one rising edge, then leave #1 for input changes.
    task automatic adv();
        bit en;
        @(posedge clka);
        cyc++;
        if (!rsta_n) begin
            m_q.delete();
            m_inf    = 0;
            m_inf_pc = 32'h0;
            m_pc     = 32'h0;
        end else begin
            en = !redirect && ((m_q.size() + m_inf) < DEPTH);
            if (redirect) begin
                m_q.delete();
                m_inf = 0;
                m_pc  = redirect_pc & ~32'h3;
            end else begin
                if (m_q.size() != 0 && instr_ready) void'(m_q.pop_front());
                if (m_inf != 0) m_q.push_back(m_inf_pc);
                m_inf = en ? 1 : 0;
                if (en) begin
                    m_inf_pc = m_pc;
                    m_pc     = m_pc + 32'h4;
                end
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cmp();
            adv();
        end
    endtask

    initial begin
        int n8;
        rsta_n       = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        instr_ready  = 1'b1;
        mem_rdata    = 32'h0;
        redirect8    = 1'b0;
        redirect_pc8 = 8'h0;
        instr_ready8 = 1'b1;
        mem_rdata8   = 32'h0;
        m_inf        = 0;
        m_inf_pc     = 32'h0;
        m_pc         = 32'h0;

        // Reset release, streaming with instr_ready high.
        run(2);
        rsta_n = 1'b1;
        cmp();
        chk("s1_first_en", 32'(mem_en), 32'h1);
        chk("s1_first_addr", mem_addr, 32'h0);
        chk("s1_valid_c0", 32'(instr_valid), 32'h0);
        adv();
        cmp();
        chk("s1_addr_c1", mem_addr, 32'h1);
        chk("s1_valid_c1", 32'(instr_valid), 32'h0);
        adv();
        cmp();
        chk("s1_valid_c2", 32'(instr_valid), 32'h1);
        chk("s1_instr_c2", instr, 32'h100);
        chk("s1_pc_c2", instr_pc, 32'h0);
        adv();
        run(4);
        chk_entry("s1_e0", dlog.size() > 0, dlog[0], 32'h0, 32'h100);
        chk_entry("s1_e1", dlog.size() > 1, dlog[1], 32'h4, 32'h101);
        chk_entry("s1_e2", dlog.size() > 2, dlog[2], 32'h8, 32'h102);
        chk_entry("s1_e3", dlog.size() > 3, dlog[3], 32'hC, 32'h103);

        // Narrow PC wraps from 0xFC to 0x00.
        chk_entry("wrap_e0", log8.size() > 0, log8[0], 32'hF8, 32'h13E);
        chk_entry("wrap_e1", log8.size() > 1, log8[1], 32'hFC, 32'h13F);
        chk_entry("wrap_e2", log8.size() > 2, log8[2], 32'h00, 32'h100);
        chk_entry("wrap_e3", log8.size() > 3, log8[3], 32'h04, 32'h101);

        // Redirect to an unaligned PC while a read is in flight.
        redirect    = 1'b1;
        redirect_pc = 32'h43;
        run(1);
        redirect = 1'b0;
        dlog.delete();
        cmp();
        chk("s3_empty", 32'(instr_valid), 32'h0);
        chk("s3_en", 32'(mem_en), 32'h1);
        chk("s3_addr", mem_addr, 32'h10);
        adv();
        run(5);
        chk_entry("s3_e0", dlog.size() > 0, dlog[0], 32'h40, 32'h110);
        chk_entry("s3_e1", dlog.size() > 1, dlog[1], 32'h44, 32'h111);

        // Backpressure: fill all entries, then drain without gaps.
        rsta_n      = 1'b0;
        instr_ready = 1'b0;
        run(1);
        rsta_n = 1'b1;
        run(8);
        cmp();
        chk("s2_full_valid", 32'(instr_valid), 32'h1);
        chk("s2_full_head", instr_pc, 32'h0);
        chk("s2_stall_en", 32'(mem_en), 32'h0);
        chk("s2_stall_addr", mem_addr, 32'h4);
        adv();
        instr_ready = 1'b1;
        dlog.delete();
        run(6);
        chk_entry("s2_e0", dlog.size() > 0, dlog[0], 32'h0, 32'h100);
        chk_entry("s2_e1", dlog.size() > 1, dlog[1], 32'h4, 32'h101);
        chk_entry("s2_e2", dlog.size() > 2, dlog[2], 32'h8, 32'h102);
        chk_entry("s2_e3", dlog.size() > 3, dlog[3], 32'hC, 32'h103);
        chk_entry("s2_e4", dlog.size() > 4, dlog[4], 32'h10, 32'h104);
        chk("s2_nogap", (dlog.size() > 4) ? 32'(dlog[4].cyc - dlog[0].cyc) : 32'hFFFF_FFFF, 32'h4);

        // Redirect coincident with the pop of head 0x8.
        rsta_n      = 1'b0;
        instr_ready = 1'b0;
        run(1);
        rsta_n = 1'b1;
        run(6);
        dlog.delete();
        instr_ready = 1'b1;
        run(2);
        redirect    = 1'b1;
        redirect_pc = 32'h80;
        run(1);
        redirect = 1'b0;
        cmp();
        chk("s4_empty", 32'(instr_valid), 32'h0);
        adv();
        run(5);
        chk_entry("s4_e0", dlog.size() > 0, dlog[0], 32'h0, 32'h100);
        chk_entry("s4_e1", dlog.size() > 1, dlog[1], 32'h4, 32'h101);
        chk_entry("s4_e2", dlog.size() > 2, dlog[2], 32'h8, 32'h102);
        chk_entry("s4_e3", dlog.size() > 3, dlog[3], 32'h80, 32'h120);
        chk_entry("s4_e4", dlog.size() > 4, dlog[4], 32'h84, 32'h121);
        n8 = 0;
        foreach (dlog[i]) if (dlog[i].pc == 32'h8) n8++;
        chk("s4_once", 32'(n8), 32'h1);

        // Asynchronous reset mid-read with three entries held.
        rsta_n      = 1'b0;
        instr_ready = 1'b0;
        run(1);
        rsta_n = 1'b1;
        run(4);
        cmp();
        chk("s5_held_valid", 32'(instr_valid), 32'h1);
        chk("s5_held_head", instr_pc, 32'h0);
        #2;
        rsta_n = 1'b0;
        #1;
        chk("s5_async_valid", 32'(instr_valid), 32'h0);
        chk("s5_async_en", 32'(mem_en), 32'h0);
        chk("s5_async_instr", instr, 32'h0);
        adv();
        run(1);
        rsta_n      = 1'b1;
        instr_ready = 1'b1;
        dlog.delete();
        run(5);
        chk_entry("s5_e0", dlog.size() > 0, dlog[0], 32'h0, 32'h100);
        chk_entry("s5_e1", dlog.size() > 1, dlog[1], 32'h4, 32'h101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning byte-address/PC width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch byte address.
REQ-005 SHALL have port clka  input  1  meaning the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rsta_n  input  1  meaning asynchronous, active-low reset.
REQ-007 SHALL have port redirect  input  1  meaning flush and restart fetch.
REQ-008 SHALL have port redirect_pc  input  ADDR_W  meaning new fetch byte address.
REQ-009 SHALL have port mem_en  output  1  meaning read enable to the synchronous block ROM.
REQ-010 SHALL have port mem_addr  output  ADDR_W  meaning word address, i.e. pc>>2 zero-extended.
REQ-011 SHALL have port mem_rdata  input  DATA_W  meaning ROM data, valid the cycle after the mem_en edge.
REQ-012 SHALL have port instr_valid  output  1  meaning queue head holds an instruction.
REQ-013 SHALL have port instr_ready  input  1  meaning consumer accepts head.
REQ-014 SHALL have port instr  output  DATA_W  meaning head instruction.
REQ-015 SHALL have port instr_pc  output  ADDR_W  meaning byte PC of head instruction.

Function
REQ-016 SHALL hold fetch PC register pc; mem_addr = pc>>2 combinationally.
REQ-017 SHALL drive mem_en = !redirect && (count + inflight < DEPTH); count = occupied entries, inflight = 1 if a read was issued last edge and is unkilled.
REQ-018 SHALL increment pc by 4 on each edge with mem_en=1, wrapping modulo 2^ADDR_W.
REQ-019 SHALL write {pc_of_issue, mem_rdata} into the queue at the edge ending the cycle after issue (read-to-valid latency 2 edges).
REQ-020 SHALL present head combinationally: instr_valid = (count != 0); instr/instr_pc = head entry.
REQ-021 SHALL pop on an edge with instr_valid && instr_ready; instr_ready while empty has no effect.
REQ-022 SHALL support simultaneous push and pop, count unchanged, ordering preserved.
REQ-023 SHALL never overflow; credit rule REQ-017 guarantees space for every in-flight response.
REQ-024 SHALL on redirect edge: empty the queue, kill the in-flight response (not written), load pc = redirect_pc with bits [1:0] forced to 0.
REQ-025 SHALL treat a pop coincident with redirect as completed; the flushed queue has count 0 afterwards.
REQ-026 SHALL resume issuing the cycle after redirect; the first redirected instruction is valid 2 edges after that issue.
REQ-027 SHALL keep mem_addr stable while mem_en=0 (stall) without changing pc.

Reset
REQ-028 SHALL on rsta_n=0 immediately set pc=RESET_PC (bits [1:0] zeroed), count=0, inflight=0, queue pointers 0, instr_valid=0, mem_en=0.
REQ-029 SHALL drive instr and instr_pc to 0 while the queue is empty.
REQ-030 SHALL discard any response whose issue preceded a reset assertion, including reset mid-read.
REQ-031 SHALL issue the first fetch in the first cycle after rsta_n deasserts.

Structure
REQ-032 SHALL place WORD_BYTES=4, the default RESET_PC, and the entry struct {pc, instr} in the shared package fetch_pkg.
REQ-033 SHALL implement storage in one sub-module, fetch_fifo (DEPTH entries, $clog2(DEPTH)+1-bit count, wrap-around pointers).
REQ-034 SHALL keep the block ROM outside this module; mem_* ports connect to the existing ROM wrapper.

Verification
REQ-035 SHALL cover reset release with RESET_PC=0, instr_ready=1, ROM[i]=i+0x100 -> mem_addr 0,1,2...; instr_valid rises on edge 2; instr/instr_pc = 0x100/0x0, 0x101/0x4, ... one per cycle.
REQ-036 SHALL cover backpressure with instr_ready=0, DEPTH=4 -> exactly 4 entries filled, mem_en low, pc frozen at 0x10; raising instr_ready drains 0x0..0xC with no gap or loss.
REQ-037 SHALL cover redirect to 0x43 with a read in flight -> queue empty next cycle; killed word never appears; next instr_pc=0x40, then 0x44.
REQ-038 SHALL cover redirect coincident with pop of head 0x8 -> 0x8 consumed once; no stale entry after flush.
REQ-039 SHALL cover wrap with ADDR_W=8, RESET_PC=0xF8 -> instr_pc sequence 0xF8, 0xFC, 0x00, 0x04.
REQ-040 SHALL cover rsta_n pulsed low mid-operation with 3 entries held -> instr_valid=0 and mem_en=0 immediately (asynchronous); fetch restarts at RESET_PC.
